midi_uart_rx: RTL and testbench
===============================

// Module: midi_uart_rx
// PURPOSE
//  Parametrised serial receiver for the MIDI input path: samples the async din line,
//  deframes start/data/stop, and presents each word on a valid/ready output register.
//  Generalises the fixed 8N1 MIDI receiver: configurable width and bit period, glitch
//  rejection, framing/overrun detection, and an optional parity stage. Feeds the MIDI FIFO.
// PARAMETERS
//  CYCLES_PER_BIT  1600  clk cycles per serial bit (50 MHz / 31250 baud); must be even and >= 8
//  DATA_BITS       8     data bits per frame, 5..9, received LSB first
//  PARITY_ODD      0     parity sense when MIDI_RX_PARITY_EN is defined (0 = even, 1 = odd)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high
//  din        in   1          async serial line, idles high
//  dout       out  DATA_BITS  received word, stable while valid=1
//  valid      out  1          dout holds an unconsumed word
//  ready      in   1          consumer accepts dout when valid && ready
//  frame_err  out  1          1-cycle pulse: stop bit sampled low
//  parity_err out  1          1-cycle pulse: parity mismatch (tied 0 when feature is off)
//  overrun    out  1          1-cycle pulse: word completed while valid && !ready
// BEHAVIOUR
//  - Reset: state=IDLE; counters 0; dout=0; valid=0; all error pulses 0; sync flops = 1.
//    Reset asserted mid-frame aborts the frame with no output and no error pulse.
//  - din passes through a 2-flop synchroniser (rxs). All sampling uses rxs only.
//  - Bit counter: $clog2(CYCLES_PER_BIT) bits. Sample point = counter == CYCLES_PER_BIT-1.
//  - IDLE: rxs==0 -> START, cnt=0.
//  - START: at cnt==CYCLES_PER_BIT/2-1 sample rxs. If 1, glitch -> IDLE (no pulse).
//    If 0 -> DATA, cnt=0, bit index=0.
//  - DATA: every CYCLES_PER_BIT cycles, shift rxs into shift reg MSB side (LSB-first
//    assembly). After DATA_BITS samples -> PARITY (feature on) or STOP.
//  - PARITY: one bit period; compare rxs with XOR(data)^PARITY_ODD; latch mismatch flag.
//  - STOP: one bit period, sample rxs.
//      rxs==1 and no parity mismatch -> deliver word, go IDLE the same cycle (back-to-back
//      frames need no idle gap; next start edge is caught from the half stop bit).
//      rxs==0 -> frame_err pulse, word dropped, go BREAK.
//      parity mismatch with rxs==1 -> parity_err pulse, word dropped, go IDLE.
//  - BREAK: wait until rxs==1, then IDLE. Holding line low (MIDI break) yields a single
//    frame_err, never repeated words.
//  - Deliver: if !valid or (valid && ready) in that cycle -> dout<=word, valid<=1 next cycle.
//    If valid && !ready -> keep old dout, drop new word, overrun pulse.
//  - Handshake: valid stays high and dout stable until the valid && ready cycle; valid
//    clears the next cycle unless a new word is delivered in the same cycle (then valid
//    stays 1 and dout updates).
//  - Latency: valid rises 1 clk after the stop-bit sample point; din edge to sample
//    point adds 2 clk synchroniser delay.
//  - The receiver never stalls on !ready; frames are always deframed at line rate.
// CONFIGURATION
//  MIDI_RX_PARITY_EN defined: PARITY state inserted between DATA and STOP; parity_err
//    active; frame = 1 + DATA_BITS + 1 + 1 bits.
//  Not defined: no PARITY state or parity logic; parity_err tied 0; PARITY_ODD ignored;
//    frame = 1 + DATA_BITS + 1 bits (MIDI 8N1).
// TESTING (CYCLES_PER_BIT=16, DATA_BITS=8 unless noted)
//  1. Send 0x90 8N1, ready=1 -> valid pulses 1 clk, dout=0x90, no error pulses.
//  2. Send 0x90,0x3C,0x7F back-to-back, ready=0 until after third frame -> dout=0x90
//     held, two overrun pulses, then handshake releases valid.
//  3. din low for 5 clk then high -> no valid, no errors, state back in IDLE.
//  4. Frame 0x55 with stop bit 0, then line held low 100 clk -> exactly one frame_err,
//     no valid; next valid frame 0xF8 is received correctly.
//  5. MIDI_RX_PARITY_EN, PARITY_ODD=0: 0x03 with parity 0 -> dout=0x03; with parity 1
//     -> parity_err pulse, valid stays 0.
//  6. Assert reset mid-DATA of 0xAA -> valid=0, dout=0; following 0x42 received intact.

Source files
------------

// File: rtl/midi_uart_rx_if.sv
// Receive-side handshake bundle for midi_uart_rx: word/valid/ready plus the
// one-cycle error pulses. master = receiver, slave = consumer (MIDI FIFO).
interface midi_uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output dout, valid, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  dout, valid, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/midi_uart_rx.sv
// Parametrised MIDI serial receiver: synchronise, deframe start/data[/parity]/stop,
// present words on a valid/ready register. Optional parity stage: MIDI_RX_PARITY_EN.
module midi_uart_rx #(
  parameter int CYCLES_PER_BIT = 1600,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_ODD     = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           din,
  midi_uart_rx_if.master rx
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MIDI_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 at_sample;
`ifdef MIDI_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign at_sample = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    valid_d     = valid_q && !rx.ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef MIDI_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start re-check rejects pulses shorter than half a bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_sample) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef MIDI_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef MIDI_RX_PARITY_EN
      S_PARITY: begin
        if (at_sample) begin
          cnt_d     = '0;
          par_bad_d = rxs_q != ((^shift_q) ^ 1'(PARITY_ODD));
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (at_sample) begin
          cnt_d = '0;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
`ifdef MIDI_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
`endif
          end else begin
            // Leaving from the half stop bit lets a back-to-back start edge be caught.
            state_d = S_IDLE;
            if (!valid_q || rx.ready) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= din;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef MIDI_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx.parity_err = parity_err_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.dout      = dout_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: directed scenarios plus random frames, checked every
// cycle against a frame-level event model of the output register.
module tb_midi_uart_rx;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
`ifdef MIDI_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Edges from the cycle din falls to the cycle the stop-bit result is visible.
  localparam int LAT = 3 + CPB / 2 + (DB + 1 + PB) * CPB;

  typedef enum int {EV_WORD, EV_FERR, EV_PERR} ev_kind_e;
  typedef struct {
    int            t;
    ev_kind_e      kind;
    logic [DB-1:0] w;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b1;
  int   ready_mode = 0;

  midi_uart_rx_if #(.DATA_BITS(DB)) rx_if ();

  midi_uart_rx #(
    .CYCLES_PER_BIT(CPB),
    .DATA_BITS     (DB),
    .PARITY_ODD    (PODD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .rx   (rx_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t evq[$];

  logic          exp_valid = 1'b0;
  logic [DB-1:0] exp_dout = '0;
  logic          exp_ferr = 1'b0, exp_perr = 1'b0, exp_ovr = 1'b0;

  int            n_vrise, n_vcyc, n_ovr, n_ferr, n_perr, last_rise_cyc;
  logic [DB-1:0] last_rise_dout;
  logic          prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counters();
    n_vrise = 0; n_vcyc = 0; n_ovr = 0; n_ferr = 0; n_perr = 0;
    last_rise_cyc = -1; last_rise_dout = '0;
  endtask

  // Drives one whole frame starting now and schedules its expected outcome.
  task automatic send_frame(input logic [DB-1:0] w, input logic stop, input logic pflip,
                            output int k);
    ev_t ev;
    k    = cyc;
    ev.t = k + LAT;
    ev.w = w;
    if (!stop)      ev.kind = EV_FERR;
    else if (pflip) ev.kind = EV_PERR;
    else            ev.kind = EV_WORD;
    evq.push_back(ev);
    din = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      din = w[i];
      tick(CPB);
    end
`ifdef MIDI_RX_PARITY_EN
    din = (^w) ^ 1'(PODD) ^ pflip;
    tick(CPB);
`endif
    din = stop;
    tick(CPB);
  endtask

  // Reference: output register driven by frame outcomes and the ready handshake.
  initial forever begin
    @(posedge clk);
    cyc++;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    exp_ovr  = 1'b0;
    if (reset) begin
      exp_valid = 1'b0;
      exp_dout  = '0;
      evq.delete();
    end else begin
      logic took, word_now;
      logic [DB-1:0] w;
      took     = exp_valid && rx_if.ready;
      word_now = 1'b0;
      w        = '0;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        ev_t ev;
        ev = evq.pop_front();
        case (ev.kind)
          EV_WORD: begin word_now = 1'b1; w = ev.w; end
          EV_FERR: exp_ferr = 1'b1;
          EV_PERR: exp_perr = 1'b1;
          default: ;
        endcase
      end
      if (word_now) begin
        if (!exp_valid || took) begin
          exp_dout  = w;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (took) begin
        exp_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("valid", {31'b0, rx_if.valid}, {31'b0, exp_valid});
    check("dout", 32'(rx_if.dout), 32'(exp_dout));
    check("frame_err", {31'b0, rx_if.frame_err}, {31'b0, exp_ferr});
    check("parity_err", {31'b0, rx_if.parity_err}, {31'b0, exp_perr});
    check("overrun", {31'b0, rx_if.overrun}, {31'b0, exp_ovr});
    if (rx_if.valid && !prev_valid) begin
      n_vrise++;
      last_rise_cyc  = cyc;
      last_rise_dout = rx_if.dout;
    end
    n_vcyc += int'(rx_if.valid);
    n_ovr  += int'(rx_if.overrun);
    n_ferr += int'(rx_if.frame_err);
    n_perr += int'(rx_if.parity_err);
    prev_valid = rx_if.valid;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rx_if.ready = 1'b1;
      1:       rx_if.ready = 1'b0;
      default: rx_if.ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    int k;
    logic [DB-1:0] w;
    logic stop, pflip;
    rx_if.ready = 1'b1;
    clear_counters();
    tick(4);
    reset = 1'b0;
    check("reset_valid", {31'b0, rx_if.valid}, 32'd0);
    check("reset_dout", 32'(rx_if.dout), 32'd0);
    tick(2 * CPB);

    // Single word, consumer always ready: one-cycle valid at fixed latency.
    clear_counters();
    send_frame(8'h90, 1'b1, 1'b0, k);
    tick(4);
`ifdef MIDI_RX_PARITY_EN
    check("t1_latency", 32'(last_rise_cyc - k), 32'd171);
`else
    check("t1_latency", 32'(last_rise_cyc - k), 32'd155);
`endif
    check("t1_dout", 32'(last_rise_dout), 32'h90);
    check("t1_valid_cycles", 32'(n_vcyc), 32'd1);
    check("t1_no_errors", 32'(n_ferr + n_perr + n_ovr), 32'd0);

    // Three back-to-back words while stalled: first held, two overruns.
    ready_mode = 1;
    tick(2);
    clear_counters();
    send_frame(8'h90, 1'b1, 1'b0, k);
    send_frame(8'h3C, 1'b1, 1'b0, k);
    send_frame(8'h7F, 1'b1, 1'b0, k);
    tick(4);
    check("t2_overruns", 32'(n_ovr), 32'd2);
    check("t2_held_dout", 32'(rx_if.dout), 32'h90);
    check("t2_held_valid", {31'b0, rx_if.valid}, 32'd1);
    ready_mode = 0;
    tick(3);
    check("t2_released", {31'b0, rx_if.valid}, 32'd0);

    // Short low glitch is rejected silently.
    clear_counters();
    din = 1'b0;
    tick(5);
    din = 1'b1;
    tick(3 * CPB);
    check("t3_no_valid", 32'(n_vrise), 32'd0);
    check("t3_no_ferr", 32'(n_ferr), 32'd0);

    // Bad stop bit followed by a held-low break: exactly one frame_err.
    clear_counters();
    send_frame(8'h55, 1'b0, 1'b0, k);
    tick(100);
    din = 1'b1;
    tick(2 * CPB);
    check("t4_one_ferr", 32'(n_ferr), 32'd1);
    check("t4_no_valid", 32'(n_vrise), 32'd0);
    clear_counters();
    send_frame(8'hF8, 1'b1, 1'b0, k);
    tick(4);
    check("t4_after_break", 32'(last_rise_dout), 32'hF8);

`ifdef MIDI_RX_PARITY_EN
    clear_counters();
    send_frame(8'h03, 1'b1, 1'b0, k);
    tick(4);
    check("t5_good_parity", 32'(last_rise_dout), 32'h03);
    clear_counters();
    send_frame(8'h03, 1'b1, 1'b1, k);
    tick(4);
    check("t5_perr", 32'(n_perr), 32'd1);
    check("t5_no_valid", 32'(n_vrise), 32'd0);
`endif

    // Reset in the middle of the data bits of 0xAA.
    clear_counters();
    w   = 8'hAA;
    din = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      din = w[i];
      tick(CPB);
    end
    reset = 1'b1;
    din   = 1'b1;
    tick(3);
    reset = 1'b0;
    check("t6_valid", {31'b0, rx_if.valid}, 32'd0);
    check("t6_dout", 32'(rx_if.dout), 32'd0);
    tick(2 * CPB);
    check("t6_no_output", 32'(n_vrise + n_ferr + n_perr), 32'd0);
    clear_counters();
    send_frame(8'h42, 1'b1, 1'b0, k);
    tick(4);
    check("t6_next_word", 32'(last_rise_dout), 32'h42);

    // Random frames, gaps, glitches, bad stops and a random consumer.
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        din = 1'b0;
        tick(int'($urandom_range(1, 5)));
        din = 1'b1;
        tick(CPB);
      end
      w    = DB'($urandom);
      stop = ($urandom_range(0, 9) != 0);
`ifdef MIDI_RX_PARITY_EN
      pflip = ($urandom_range(0, 9) == 0);
`else
      pflip = 1'b0;
`endif
      send_frame(w, stop, pflip, k);
      if (!stop) begin
        tick(int'($urandom_range(0, 40)));
        din = 1'b1;
        tick(2 * CPB);
      end else begin
        tick(int'($urandom_range(0, CPB)));
      end
    end
    ready_mode = 0;
    tick(LAT + 2 * CPB);
    check("drain", 32'(evq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
